// File: rtl/pc_context_scheduler.sv
// Multi-context program counter: kernel is context 0, user contexts live in fixed partitions.
// Keeps a saved relative PC per context, preempts on quantum, traps to kernel, dispatches round-robin.
module pc_context_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int NUM_CTX   = 4,
  parameter int PART_SIZE = 200,
  parameter int BOOT_PC   = 199,
  localparam int CTX_W    = $clog2(NUM_CTX)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stop,
  input  logic [2:0]        desvio,
  input  logic [ADDR_W-1:0] novo_end,
  input  logic [ADDR_W-1:0] novo_end_r,
  input  logic              zero,
  input  logic              negativo,
  input  logic              def_quantum,
  input  logic              end_program,
  input  logic              change_prog,
  input  logic              lpc,
  output logic [ADDR_W-1:0] endereco,
  output logic [CTX_W-1:0]  ctx_atual,
  output logic [CTX_W-1:0]  next_ctx,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic              all_done
);

  logic [ADDR_W-1:0] quantum;
  logic [ADDR_W-1:0] inst_cnt;
  logic [ADDR_W-1:0] saved_pc [NUM_CTX];
  logic [NUM_CTX-1:0] done;

  function automatic logic [ADDR_W-1:0] base_of(input logic [CTX_W-1:0] c);
    return ADDR_W'(c) * ADDR_W'(PART_SIZE);
  endfunction

  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] rel_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] dispatch_pc;

  assign cur_base      = base_of(ctx_atual);
  assign rel_pc        = endereco - cur_base;
  assign pc_inc        = endereco + ADDR_W'(1);
  assign branch_target = novo_end + cur_base;
  assign dispatch_pc   = saved_pc[next_ctx] + base_of(next_ctx);

  logic in_user;
  logic quantum_hit;
  logic trap_take;
  logic lpc_take;

  assign in_user     = (ctx_atual != '0);
  assign quantum_hit = (quantum != '0) && (inst_cnt >= quantum);
  // A pending trap only fires on a plain sequential step; branches run first.
  assign trap_take   = !stop && in_user && (desvio == 3'b000) &&
                       (end_program || change_prog || quantum_hit);
  assign lpc_take    = !stop && !in_user && lpc && (next_ctx != '0);

  always_comb begin
    pc_next = pc_inc;
    case (desvio)
      3'b000: pc_next = pc_inc;
      3'b001: pc_next = branch_target;
      3'b010: pc_next = zero ? branch_target : pc_inc;
      3'b011: pc_next = novo_end_r;
      3'b100: pc_next = zero ? pc_inc : branch_target;
      3'b101: pc_next = negativo ? branch_target : pc_inc;
      3'b110: pc_next = (negativo | zero) ? branch_target : pc_inc;
      3'b111: pc_next = endereco;
    endcase
  end

  logic [NUM_CTX-1:0] done_after;
  logic               rr_found;
  logic [CTX_W-1:0]   rr_ctx;
  logic [CTX_W-1:0]   rr_idx;
  int                 rr_cand;
  logic [ADDR_W:0]    sys_req;
  logic [CTX_W-1:0]   sys_idx;
  logic               sys_ok;
  logic [CTX_W-1:0]   trap_next;
  logic [1:0]         cause;

  // Round-robin scan starts after the trapping context and ends on it.
  always_comb begin
    done_after = done;
    if (end_program) done_after[ctx_atual] = 1'b1;
    rr_found = 1'b0;
    rr_ctx   = '0;
    rr_cand  = 0;
    rr_idx   = '0;
    for (int k = 1; k < NUM_CTX; k++) begin
      rr_cand = ((int'(ctx_atual) + k - 1) % (NUM_CTX - 1)) + 1;
      rr_idx  = CTX_W'(rr_cand);
      if (!rr_found && !done_after[rr_idx]) begin
        rr_found = 1'b1;
        rr_ctx   = rr_idx;
      end
    end
    sys_req = {1'b0, novo_end_r} + (ADDR_W+1)'(1);
    sys_idx = CTX_W'(sys_req);
    sys_ok  = (sys_req <= (ADDR_W+1)'(NUM_CTX - 1)) && !done_after[sys_idx];
    if (change_prog && sys_ok) trap_next = sys_idx;
    else if (rr_found)         trap_next = rr_ctx;
    else                       trap_next = '0;
    if (end_program)      cause = 2'b10;
    else if (change_prog) cause = 2'b11;
    else                  cause = 2'b01;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      endereco   <= ADDR_W'(BOOT_PC);
      ctx_atual  <= '0;
      next_ctx   <= CTX_W'(1);
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      all_done   <= 1'b0;
      quantum    <= '0;
      inst_cnt   <= '0;
      done       <= '0;
      for (int i = 0; i < NUM_CTX; i++) saved_pc[i] <= '0;
    end else begin
      trap <= 1'b0;
      if (def_quantum) quantum <= novo_end_r;
      if (!stop) begin
        if (trap_take) begin
          // end_program re-executes nothing, so its saved PC is the halting instruction.
          saved_pc[ctx_atual] <= end_program ? rel_pc : rel_pc + ADDR_W'(1);
          done       <= done_after;
          next_ctx   <= trap_next;
          all_done   <= !rr_found;
          trap_cause <= cause;
          endereco   <= '0;
          ctx_atual  <= '0;
          inst_cnt   <= '0;
          trap       <= 1'b1;
        end else if (lpc_take) begin
          ctx_atual <= next_ctx;
          endereco  <= dispatch_pc;
          inst_cnt  <= '0;
        end else begin
          if (in_user && (inst_cnt != '1)) inst_cnt <= inst_cnt + ADDR_W'(1);
          endereco <= pc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_context_scheduler.sv
// Bench for pc_context_scheduler: directed scenarios plus randomized traffic
// compared against a behavioural model of the scheduler.
module tb_pc_context_scheduler;

  localparam int NC   = 4;
  localparam int PART = 200;

  logic        clock = 1'b0;
  logic        reset, stop, zero, negativo, def_quantum, end_program, change_prog, lpc;
  logic [2:0]  desvio;
  logic [31:0] novo_end, novo_end_r;
  logic [31:0] endereco;
  logic [1:0]  ctx_atual, next_ctx, trap_cause;
  logic        trap, all_done;

  int n_checks = 0;
  int n_pass   = 0;

  pc_context_scheduler dut (
    .clock(clock), .reset(reset), .stop(stop), .desvio(desvio),
    .novo_end(novo_end), .novo_end_r(novo_end_r), .zero(zero), .negativo(negativo),
    .def_quantum(def_quantum), .end_program(end_program), .change_prog(change_prog),
    .lpc(lpc), .endereco(endereco), .ctx_atual(ctx_atual), .next_ctx(next_ctx),
    .trap(trap), .trap_cause(trap_cause), .all_done(all_done)
  );

  always #5 clock = ~clock;

  // Behavioural model state
  logic [31:0] m_pc, m_q, m_cnt;
  logic [31:0] m_saved [NC];
  bit          m_done  [NC];
  int          m_ctx, m_next, m_cause;
  bit          m_trap, m_all;

  function automatic void model_step();
    logic [31:0] base, tgt, nq;
    bit taken;
    int c, runnable;
    if (reset) begin
      m_pc = 199; m_ctx = 0; m_next = 1; m_trap = 0; m_cause = 0; m_all = 0;
      m_q = 0; m_cnt = 0;
      for (int i = 0; i < NC; i++) begin m_saved[i] = 0; m_done[i] = 0; end
      return;
    end
    nq = def_quantum ? novo_end_r : m_q;
    m_trap = 0;
    if (!stop) begin
      base = 32'(m_ctx * PART);
      if (m_ctx != 0 && desvio == 3'b000 &&
          (end_program || change_prog || (m_q != 0 && m_cnt >= m_q))) begin
        m_saved[m_ctx] = m_pc - base + (end_program ? 32'd0 : 32'd1);
        if (end_program) m_done[m_ctx] = 1;
        m_cause = end_program ? 2 : (change_prog ? 3 : 1);
        runnable = 0;
        for (int i = 1; i < NC; i++) if (!m_done[i]) runnable++;
        if (change_prog && novo_end_r < NC - 1 && !m_done[novo_end_r + 1]) begin
          m_next = int'(novo_end_r) + 1;
        end else if (runnable == 0) begin
          m_next = 0;
        end else begin
          c = m_ctx;
          do c = (c == NC - 1) ? 1 : c + 1; while (m_done[c]);
          m_next = c;
        end
        m_all = (runnable == 0);
        m_pc = 0; m_ctx = 0; m_cnt = 0; m_trap = 1;
      end else if (m_ctx == 0 && lpc && m_next != 0) begin
        m_ctx = m_next;
        m_pc  = m_saved[m_next] + 32'(m_next * PART);
        m_cnt = 0;
      end else begin
        if (m_ctx != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        tgt = novo_end + base;
        case (desvio)
          3'b001: m_pc = tgt;
          3'b010: m_pc = zero ? tgt : m_pc + 1;
          3'b011: m_pc = novo_end_r;
          3'b100: m_pc = zero ? m_pc + 1 : tgt;
          3'b101: m_pc = negativo ? tgt : m_pc + 1;
          3'b110: m_pc = (negativo || zero) ? tgt : m_pc + 1;
          3'b111: m_pc = m_pc;
          default: m_pc = m_pc + 1;
        endcase
      end
    end
    m_q = nq;
  endfunction

  task automatic idle();
    reset = 0; stop = 0; desvio = 3'b000; novo_end = 0; novo_end_r = 0;
    zero = 0; negativo = 0; def_quantum = 0; end_program = 0; change_prog = 0; lpc = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); reset = 1; tick();
    n_checks++; if (endereco !== 32'd199) $display("FAIL reset_endereco got %0d exp 199", endereco); else n_pass++;
    n_checks++; if (ctx_atual !== 2'd0) $display("FAIL reset_ctx got %0d exp 0", ctx_atual); else n_pass++;
    n_checks++; if (next_ctx !== 2'd1) $display("FAIL reset_next got %0d exp 1", next_ctx); else n_pass++;
    n_checks++; if ({trap, trap_cause, all_done} !== 4'b0000)
      $display("FAIL reset_flags got trap=%0b cause=%0d all_done=%0b exp 0/0/0", trap, trap_cause, all_done);
    else n_pass++;
  endtask

  task automatic test_kernel_seq();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (endereco !== 32'(200 + i) || ctx_atual !== 2'd0)
        $display("FAIL kernel_seq step %0d got pc=%0d ctx=%0d exp pc=%0d ctx=0", i, endereco, ctx_atual, 200 + i);
      else n_pass++;
    end
  endtask

  task automatic test_branches();
    int          dv [11] = '{2, 2, 4, 4, 5, 5, 6, 6, 3, 7, 0};
    bit          zt [11] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    bit          nt [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int          ne [11] = '{50, 0, 10, 10, 30, 30, 90, 90, 0, 0, 0};
    int          ex [11] = '{50, 51, 52, 10, 30, 31, 32, 90, 1234, 1234, 1235};
    reset = 1; tick();
    for (int i = 0; i < 11; i++) begin
      desvio = 3'(dv[i]); zero = zt[i]; negativo = nt[i]; novo_end = 32'(ne[i]); novo_end_r = 32'd1234;
      tick();
      n_checks++; if (endereco !== 32'(ex[i]))
        $display("FAIL branch_row %0d desvio=%0d got %0d exp %0d", i, dv[i], endereco, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_dispatch_branch();
    reset = 1; tick();
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd200 || ctx_atual !== 2'd1)
      $display("FAIL dispatch got pc=%0d ctx=%0d exp pc=200 ctx=1", endereco, ctx_atual);
    else n_pass++;
    desvio = 3'b001; novo_end = 5; tick();
    n_checks++; if (endereco !== 32'd205) $display("FAIL user_branch got %0d exp 205", endereco); else n_pass++;
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd206 || ctx_atual !== 2'd1)
      $display("FAIL lpc_in_user got pc=%0d ctx=%0d exp pc=206 ctx=1", endereco, ctx_atual);
    else n_pass++;
  endtask

  task automatic test_quantum_trap();
    reset = 1; tick();
    def_quantum = 1; novo_end_r = 3; tick();
    lpc = 1; tick();
    tick(); tick(); tick();
    n_checks++; if (endereco !== 32'd203 || trap !== 1'b0)
      $display("FAIL quantum_run got pc=%0d trap=%0b exp pc=203 trap=0", endereco, trap);
    else n_pass++;
    tick();
    n_checks++; if (trap !== 1'b1 || trap_cause !== 2'b01)
      $display("FAIL quantum_trap got trap=%0b cause=%0d exp trap=1 cause=1", trap, trap_cause);
    else n_pass++;
    n_checks++; if (endereco !== 32'd0 || ctx_atual !== 2'd0 || next_ctx !== 2'd2)
      $display("FAIL quantum_state got pc=%0d ctx=%0d next=%0d exp 0/0/2", endereco, ctx_atual, next_ctx);
    else n_pass++;
    tick();
    n_checks++; if (trap !== 1'b0 || trap_cause !== 2'b01)
      $display("FAIL trap_pulse got trap=%0b cause=%0d exp trap=0 cause=1", trap, trap_cause);
    else n_pass++;
  endtask

  task automatic test_end_program();
    def_quantum = 1; novo_end_r = 0; tick();
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd400 || ctx_atual !== 2'd2)
      $display("FAIL ctx2_dispatch got pc=%0d ctx=%0d exp 400/2", endereco, ctx_atual);
    else n_pass++;
    desvio = 3'b001; novo_end = 10; tick();
    end_program = 1; tick();
    n_checks++; if (trap !== 1'b1 || trap_cause !== 2'b10 || next_ctx !== 2'd3 || all_done !== 1'b0)
      $display("FAIL end_prog got trap=%0b cause=%0d next=%0d all=%0b exp 1/2/3/0", trap, trap_cause, next_ctx, all_done);
    else n_pass++;
  endtask

  task automatic test_change_prog();
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd600 || ctx_atual !== 2'd3)
      $display("FAIL ctx3_dispatch got pc=%0d ctx=%0d exp 600/3", endereco, ctx_atual);
    else n_pass++;
    change_prog = 1; novo_end_r = 0; tick();
    n_checks++; if (trap_cause !== 2'b11 || next_ctx !== 2'd1)
      $display("FAIL sys_to_1 got cause=%0d next=%0d exp 3/1", trap_cause, next_ctx);
    else n_pass++;
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd204 || ctx_atual !== 2'd1)
      $display("FAIL ctx1_restore got pc=%0d ctx=%0d exp 204/1", endereco, ctx_atual);
    else n_pass++;
    change_prog = 1; novo_end_r = 2; tick();
    n_checks++; if (next_ctx !== 2'd3) $display("FAIL sys_to_3 got %0d exp 3", next_ctx); else n_pass++;
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd601) $display("FAIL ctx3_restore got %0d exp 601", endereco); else n_pass++;
    change_prog = 1; novo_end_r = 9; tick();
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd205 || ctx_atual !== 2'd1)
      $display("FAIL sys_bad_rr got pc=%0d ctx=%0d exp 205/1", endereco, ctx_atual);
    else n_pass++;
    change_prog = 1; novo_end_r = 1; tick();
    n_checks++; if (next_ctx !== 2'd3) $display("FAIL sys_done_skip got %0d exp 3", next_ctx); else n_pass++;
    lpc = 1; tick();
    end_program = 1; tick();
    n_checks++; if (next_ctx !== 2'd1 || all_done !== 1'b0)
      $display("FAIL end3 got next=%0d all=%0b exp 1/0", next_ctx, all_done);
    else n_pass++;
    lpc = 1; tick();
    end_program = 1; tick();
    n_checks++; if (next_ctx !== 2'd0 || all_done !== 1'b1)
      $display("FAIL all_done got next=%0d all=%0b exp 0/1", next_ctx, all_done);
    else n_pass++;
    lpc = 1; tick();
    n_checks++; if (endereco !== 32'd1 || ctx_atual !== 2'd0)
      $display("FAIL lpc_none got pc=%0d ctx=%0d exp 1/0", endereco, ctx_atual);
    else n_pass++;
  endtask

  task automatic test_deferred_stop();
    reset = 1; tick();
    def_quantum = 1; novo_end_r = 2; tick();
    lpc = 1; tick();
    tick(); tick();
    desvio = 3'b001; novo_end = 7; tick();
    n_checks++; if (endereco !== 32'd207 || trap !== 1'b0)
      $display("FAIL deferred_branch got pc=%0d trap=%0b exp 207/0", endereco, trap);
    else n_pass++;
    stop = 1; end_program = 1; def_quantum = 1; novo_end_r = 0; tick();
    n_checks++; if (endereco !== 32'd207 || trap !== 1'b0 || ctx_atual !== 2'd1)
      $display("FAIL stop_freeze got pc=%0d trap=%0b ctx=%0d exp 207/0/1", endereco, trap, ctx_atual);
    else n_pass++;
    tick();
    n_checks++; if (endereco !== 32'd208 || trap !== 1'b0)
      $display("FAIL quantum_zero got pc=%0d trap=%0b exp 208/0", endereco, trap);
    else n_pass++;
    def_quantum = 1; novo_end_r = 1; tick();
    tick();
    n_checks++; if (trap !== 1'b1 || trap_cause !== 2'b01 || next_ctx !== 2'd2)
      $display("FAIL late_trap got trap=%0b cause=%0d next=%0d exp 1/1/2", trap, trap_cause, next_ctx);
    else n_pass++;
  endtask

  task automatic test_random();
    reset = 1; tick();
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      stop        = ($urandom_range(0, 7) == 0);
      desvio      = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      novo_end    = 32'($urandom_range(0, 250));
      novo_end_r  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4));
      zero        = 1'($urandom_range(0, 1));
      negativo    = 1'($urandom_range(0, 1));
      def_quantum = ($urandom_range(0, 15) == 0);
      end_program = ($urandom_range(0, 24) == 0);
      change_prog = ($urandom_range(0, 9) == 0);
      lpc         = ($urandom_range(0, 2) == 0);
      tick();
      n_checks++; if (endereco !== m_pc) $display("FAIL rnd_pc cyc %0d got %0d exp %0d", i, endereco, m_pc); else n_pass++;
      n_checks++; if (ctx_atual !== 2'(m_ctx)) $display("FAIL rnd_ctx cyc %0d got %0d exp %0d", i, ctx_atual, m_ctx); else n_pass++;
      n_checks++; if (next_ctx !== 2'(m_next)) $display("FAIL rnd_next cyc %0d got %0d exp %0d", i, next_ctx, m_next); else n_pass++;
      n_checks++; if (trap !== m_trap) $display("FAIL rnd_trap cyc %0d got %0b exp %0b", i, trap, m_trap); else n_pass++;
      n_checks++; if (trap_cause !== 2'(m_cause)) $display("FAIL rnd_cause cyc %0d got %0d exp %0d", i, trap_cause, m_cause); else n_pass++;
      n_checks++; if (all_done !== m_all) $display("FAIL rnd_all_done cyc %0d got %0b exp %0b", i, all_done, m_all); else n_pass++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_kernel_seq();
    test_branches();
    test_dispatch_branch();
    test_quantum_trap();
    test_end_program();
    test_change_prog();
    test_deferred_stop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
